// File: rtl/vending_pkg.sv
// Shared types and constants for the vending machine controller.
// State encoding, one-hot item codes and item prices.
package vending_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      VEND    = 2'd2,
      CHANGE  = 2'd3
   } state_e;

   localparam logic [3:0] ITEM_A = 4'b0001;
   localparam logic [3:0] ITEM_B = 4'b0010;
   localparam logic [3:0] ITEM_C = 4'b0100;
   localparam logic [3:0] ITEM_D = 4'b1000;

   localparam logic [2:0] PRICE_A = 3'd1;
   localparam logic [2:0] PRICE_B = 3'd2;
   localparam logic [2:0] PRICE_C = 3'd3;
   localparam logic [2:0] PRICE_D = 3'd5;

endpackage

// File: rtl/item_price_lut.sv
// Combinational price lookup: one-hot item select -> price in units.
// onehot_o is low for any pattern that is not exactly one bit set
// (including all-zero); price_o is 0 in that case.
module item_price_lut
   import vending_pkg::*;
(
   input  logic [3:0] item_sel_i,
   output logic [2:0] price_o,
   output logic       onehot_o
);

   // Decode the select into a price and flag illegal selects
   always_comb begin
      price_o  = '0;
      onehot_o = 1'b1;
      case (item_sel_i)
         ITEM_A:  price_o = PRICE_A;
         ITEM_B:  price_o = PRICE_B;
         ITEM_C:  price_o = PRICE_C;
         ITEM_D:  price_o = PRICE_D;
         default: onehot_o = 1'b0;
      endcase
   end

endmodule

// File: rtl/vending_controller.sv
// Vending machine sequencing FSM: coin credit, item selection, dispense
// handshake and unit-by-unit change return. All outputs are registered.
// Optional feature macro: VEND_TIMEOUT_EN -- inactivity auto-refund in COLLECT.
module vending_controller
   import vending_pkg::*;
#(
   parameter int CREDIT_W       = 4,
   parameter int MAX_CREDIT     = 15,
   parameter int TIMEOUT_CYCLES = 1000
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                coin_valid,
   input  logic [1:0]          coin_value,
   input  logic                sel_valid,
   input  logic [3:0]          item_sel,
   input  logic                cancel,
   input  logic                vend_ready,
   output logic                vend_valid,
   output logic [3:0]          vend_item,
   output logic                change_pulse,
   output logic [CREDIT_W-1:0] credit,
   output logic                busy,
   output logic                coin_reject,
   output logic                sel_err,
   output logic                sel_insuff
);

   localparam int SUM_W = CREDIT_W + 1;

   state_e              state_q, state_d;
   logic [CREDIT_W-1:0] credit_q, credit_d;
   logic [3:0]          item_q, item_d;
   logic                vend_valid_q, change_pulse_q, busy_q;
   logic                coin_reject_q, coin_reject_d;
   logic                sel_err_q, sel_err_d;
   logic                sel_insuff_q, sel_insuff_d;

   logic [2:0]          price;
   logic                sel_onehot;
   logic                coin_ev;
   logic [SUM_W-1:0]    coin_sum;
   logic                coin_fits;
   logic                price_ok;
   logic                activity;     // accepted coin or acted-on selection
   logic                timeout_hit;

   item_price_lut u_lut (
      .item_sel_i (item_sel),
      .price_o    (price),
      .onehot_o   (sel_onehot)
   );

   // A zero-valued coin strobe is treated as no coin at all
   assign coin_ev   = coin_valid && (coin_value != 2'd0);
   assign coin_sum  = {1'b0, credit_q} + SUM_W'(coin_value);
   assign coin_fits = (coin_sum <= SUM_W'(MAX_CREDIT));
   assign price_ok  = (CREDIT_W'(price) <= credit_q);

   // Next-state, credit and pulse decode; one event per cycle in IDLE/COLLECT
   always_comb begin
      state_d       = state_q;
      credit_d      = credit_q;
      item_d        = item_q;
      coin_reject_d = 1'b0;
      sel_err_d     = 1'b0;
      sel_insuff_d  = 1'b0;
      activity      = 1'b0;
      case (state_q)
         IDLE, COLLECT: begin
            if (cancel) begin
               state_d = (credit_q != '0) ? CHANGE : IDLE;
            end else if (coin_ev) begin
               if (coin_fits) begin
                  credit_d = coin_sum[CREDIT_W-1:0];
                  state_d  = COLLECT;
                  activity = 1'b1;
               end else begin
                  coin_reject_d = 1'b1;
               end
            end else if (sel_valid) begin
               activity = 1'b1;
               if (!sel_onehot) begin
                  sel_err_d = 1'b1;
               end else if (!price_ok) begin
                  sel_insuff_d = 1'b1;
               end else begin
                  credit_d = credit_q - CREDIT_W'(price);
                  item_d   = item_sel;
                  state_d  = VEND;
               end
            end else if (state_q == COLLECT && timeout_hit) begin
               state_d = CHANGE;
            end
         end
         VEND: begin
            coin_reject_d = coin_ev;
            if (vend_ready) state_d = (credit_q != '0) ? CHANGE : IDLE;
         end
         CHANGE: begin
            coin_reject_d = coin_ev;
            if (credit_q <= CREDIT_W'(1)) begin
               credit_d = '0;
               state_d  = IDLE;
            end else begin
               credit_d = credit_q - 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

`ifdef VEND_TIMEOUT_EN
   localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

   logic [TO_W-1:0] to_cnt_q, to_cnt_d;

   // Counter holds the number of quiet cycles already spent in COLLECT
   assign timeout_hit = (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

   // Count quiet cycles in COLLECT; saturate so a rejected coin cannot wrap it
   always_comb begin
      to_cnt_d = '0;
      if (state_q == COLLECT && state_d == COLLECT && !activity)
         to_cnt_d = timeout_hit ? to_cnt_q : to_cnt_q + 1'b1;
   end

   // Inactivity counter register
   always_ff @(posedge clk) begin
      if (!rst_n) to_cnt_q <= '0;
      else        to_cnt_q <= to_cnt_d;
   end
`else
   logic unused_timeout;

   assign timeout_hit    = 1'b0;
   assign unused_timeout = activity ^ (TIMEOUT_CYCLES != 0);
`endif

   // State, credit and registered outputs
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q        <= IDLE;
         credit_q       <= '0;
         item_q         <= '0;
         vend_valid_q   <= 1'b0;
         change_pulse_q <= 1'b0;
         busy_q         <= 1'b0;
         coin_reject_q  <= 1'b0;
         sel_err_q      <= 1'b0;
         sel_insuff_q   <= 1'b0;
      end else begin
         state_q        <= state_d;
         credit_q       <= credit_d;
         item_q         <= item_d;
         vend_valid_q   <= (state_d == VEND);
         change_pulse_q <= (state_d == CHANGE);
         busy_q         <= (state_d == VEND) || (state_d == CHANGE);
         coin_reject_q  <= coin_reject_d;
         sel_err_q      <= sel_err_d;
         sel_insuff_q   <= sel_insuff_d;
      end
   end

   assign vend_valid   = vend_valid_q;
   assign vend_item    = item_q;
   assign change_pulse = change_pulse_q;
   assign credit       = credit_q;
   assign busy         = busy_q;
   assign coin_reject  = coin_reject_q;
   assign sel_err      = sel_err_q;
   assign sel_insuff   = sel_insuff_q;

endmodule

// File: tb/tb_vending_controller.sv
// Self-checking bench for vending_controller: directed scenarios plus a
// randomized run compared against a transaction-level model of the machine.
// Honours VEND_TIMEOUT_EN (timeout scenario uses TIMEOUT_CYCLES=8).
module tb_vending_controller;

   localparam int TO = 8;
   localparam int MAXC = 15;

   logic       clk = 1'b0;
   logic       rst_n, coin_valid, sel_valid, cancel, vend_ready;
   logic [1:0] coin_value;
   logic [3:0] item_sel;
   logic       vend_valid, change_pulse, busy, coin_reject, sel_err, sel_insuff;
   logic [3:0] vend_item, credit;

   int tests = 0;
   int fails = 0;

   // Model: machine mode (0 idle, 1 collecting, 2 dispensing, 3 refunding),
   // credit held, item being dispensed, quiet cycles while collecting.
   int         m_mode, m_credit, m_idle;
   logic [3:0] m_item;
   bit         m_rej, m_serr, m_sins;

   always #5 clk = ~clk;

   vending_controller #(.CREDIT_W(4), .MAX_CREDIT(MAXC), .TIMEOUT_CYCLES(TO)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .coin_valid   (coin_valid),
      .coin_value   (coin_value),
      .sel_valid    (sel_valid),
      .item_sel     (item_sel),
      .cancel       (cancel),
      .vend_ready   (vend_ready),
      .vend_valid   (vend_valid),
      .vend_item    (vend_item),
      .change_pulse (change_pulse),
      .credit       (credit),
      .busy         (busy),
      .coin_reject  (coin_reject),
      .sel_err      (sel_err),
      .sel_insuff   (sel_insuff)
   );

   function automatic int price_of(logic [3:0] s);
      case (s)
         4'b0001: return 1;
         4'b0010: return 2;
         4'b0100: return 3;
         4'b1000: return 5;
         default: return -1;
      endcase
   endfunction

   // Apply the machine's rules to the inputs seen at this clock edge
   task automatic model_step();
      bit coin_ev;
      int p;
      coin_ev = coin_valid && (coin_value != 0);
      m_rej = 0; m_serr = 0; m_sins = 0;
      if (!rst_n) begin
         m_mode = 0; m_credit = 0; m_item = '0; m_idle = 0;
         return;
      end
      case (m_mode)
         0, 1: begin
            if (cancel) m_mode = (m_credit > 0) ? 3 : 0;
            else if (coin_ev) begin
               if (m_credit + int'(coin_value) <= MAXC) begin
                  m_credit += int'(coin_value); m_mode = 1; m_idle = 0;
               end else begin
                  m_rej = 1; m_idle++;
               end
            end else if (sel_valid) begin
               m_idle = 0;
               p = price_of(item_sel);
               if (p < 0) m_serr = 1;
               else if (p > m_credit) m_sins = 1;
               else begin m_credit -= p; m_item = item_sel; m_mode = 2; end
            end else if (m_mode == 1) begin
`ifdef VEND_TIMEOUT_EN
               if (m_idle + 1 >= TO) m_mode = 3;
               else m_idle++;
`else
               m_idle++;
`endif
            end
         end
         2: begin
            m_rej = coin_ev;
            if (vend_ready) m_mode = (m_credit > 0) ? 3 : 0;
         end
         default: begin
            m_rej = coin_ev;
            m_credit--;
            if (m_credit <= 0) begin m_credit = 0; m_mode = 0; end
         end
      endcase
      if (m_mode != 1) m_idle = 0;
   endtask

   // Advance one clock; inputs are driven and outputs sampled on negedges
   task automatic cycle();
      @(posedge clk);
      model_step();
      @(negedge clk);
   endtask

   task automatic quiet_inputs();
      coin_valid = 0; coin_value = 0; sel_valid = 0; item_sel = 0;
      cancel = 0; vend_ready = 0;
   endtask

   task automatic do_reset();
      quiet_inputs();
      rst_n = 0;
      cycle(); cycle();
      rst_n = 1;
   endtask

   task automatic coin(int v);
      coin_valid = 1; coin_value = 2'(v);
      cycle();
      coin_valid = 0; coin_value = 0;
   endtask

   task automatic sel(logic [3:0] s);
      sel_valid = 1; item_sel = s;
      cycle();
      sel_valid = 0; item_sel = 0;
   endtask

   task automatic test_reset();
      coin_valid = 1; coin_value = 2'd3; sel_valid = 1; item_sel = 4'b0001;
      rst_n = 0;
      cycle(); cycle();
      quiet_inputs();
      rst_n = 1;
      tests++;
      if ({credit, vend_valid, change_pulse, busy, vend_item, coin_reject, sel_err, sel_insuff} !== 15'd0) begin
         fails++;
         $display("FAIL reset: outputs=%h required 0",
                  {credit, vend_valid, change_pulse, busy, vend_item, coin_reject, sel_err, sel_insuff});
      end
   endtask

   task automatic test_vend_change();
      do_reset();
      coin(2); coin(2);
      sel(4'b0100);
      tests++;
      if (vend_valid !== 1'b1 || vend_item !== 4'b0100 || credit !== 4'd1 || busy !== 1'b1) begin
         fails++;
         $display("FAIL vend_start: vv=%b item=%b credit=%0d busy=%b required 1 0100 1 1",
                  vend_valid, vend_item, credit, busy);
      end
      for (int i = 0; i < 3; i++) begin
         cycle();
         tests++;
         if (vend_valid !== 1'b1 || vend_item !== 4'b0100) begin
            fails++;
            $display("FAIL vend_hold%0d: vv=%b item=%b required 1 0100", i, vend_valid, vend_item);
         end
      end
      vend_ready = 1;
      cycle();
      vend_ready = 0;
      tests++;
      if (vend_valid !== 1'b0 || change_pulse !== 1'b1 || credit !== 4'd1) begin
         fails++;
         $display("FAIL vend_handshake: vv=%b cp=%b credit=%0d required 0 1 1",
                  vend_valid, change_pulse, credit);
      end
      cycle();
      tests++;
      if (change_pulse !== 1'b0 || credit !== 4'd0 || busy !== 1'b0) begin
         fails++;
         $display("FAIL change_done: cp=%b credit=%0d busy=%b required 0 0 0",
                  change_pulse, credit, busy);
      end
   endtask

   task automatic test_insufficient();
      do_reset();
      coin(3);
      sel(4'b1000);
      tests++;
      if (sel_insuff !== 1'b1 || credit !== 4'd3 || vend_valid !== 1'b0) begin
         fails++;
         $display("FAIL sel_insuff: ins=%b credit=%0d vv=%b required 1 3 0", sel_insuff, credit, vend_valid);
      end
      cycle();
      tests++;
      if (sel_insuff !== 1'b0 || vend_valid !== 1'b0 || busy !== 1'b0) begin
         fails++;
         $display("FAIL insuff_after: ins=%b vv=%b busy=%b required 0 0 0", sel_insuff, vend_valid, busy);
      end
   endtask

   task automatic test_sel_err();
      logic [3:0] pats [2];
      pats[0] = 4'b0110; pats[1] = 4'b0000;
      do_reset();
      coin(2);
      for (int i = 0; i < 2; i++) begin
         sel(pats[i]);
         tests++;
         if (sel_err !== 1'b1 || credit !== 4'd2 || busy !== 1'b0 || vend_valid !== 1'b0) begin
            fails++;
            $display("FAIL sel_err %b: err=%b credit=%0d busy=%b vv=%b required 1 2 0 0",
                     pats[i], sel_err, credit, busy, vend_valid);
         end
      end
   endtask

   task automatic test_overflow_refund();
      int pulses;
      do_reset();
      coin(3); coin(3); coin(3); coin(3); coin(2);
      coin(3);
      tests++;
      if (coin_reject !== 1'b1 || credit !== 4'd14) begin
         fails++;
         $display("FAIL coin_reject: rej=%b credit=%0d required 1 14", coin_reject, credit);
      end
      cancel = 1;
      cycle();
      cancel = 0;
      pulses = 0;
      for (int i = 0; i < 30 && change_pulse === 1'b1; i++) begin
         if (credit !== 4'(14 - pulses)) begin
            tests++; fails++;
            $display("FAIL refund_credit: pulse %0d credit=%0d required %0d", pulses, credit, 14 - pulses);
         end
         pulses++;
         cycle();
      end
      tests++;
      if (pulses !== 14 || credit !== 4'd0 || busy !== 1'b0) begin
         fails++;
         $display("FAIL refund_count: pulses=%0d credit=%0d busy=%b required 14 0 0", pulses, credit, busy);
      end
   endtask

   task automatic test_timeout();
      do_reset();
      coin(2);
`ifdef VEND_TIMEOUT_EN
      for (int i = 0; i < TO - 1; i++) begin
         cycle();
         tests++;
         if (change_pulse !== 1'b0 || credit !== 4'd2) begin
            fails++;
            $display("FAIL timeout_early %0d: cp=%b credit=%0d required 0 2", i, change_pulse, credit);
         end
      end
      cycle();
      tests++;
      if (change_pulse !== 1'b1 || credit !== 4'd2) begin
         fails++;
         $display("FAIL timeout_fire: cp=%b credit=%0d required 1 2", change_pulse, credit);
      end
      cycle();
      tests++;
      if (change_pulse !== 1'b1 || credit !== 4'd1) begin
         fails++;
         $display("FAIL timeout_pulse2: cp=%b credit=%0d required 1 1", change_pulse, credit);
      end
      cycle();
      tests++;
      if (change_pulse !== 1'b0 || credit !== 4'd0 || busy !== 1'b0) begin
         fails++;
         $display("FAIL timeout_end: cp=%b credit=%0d busy=%b required 0 0 0", change_pulse, credit, busy);
      end
`else
      begin
         bit bad;
         bad = 0;
         for (int i = 0; i < 20; i++) begin
            cycle();
            if (change_pulse !== 1'b0 || credit !== 4'd2 || busy !== 1'b0) bad = 1;
         end
         tests++;
         if (bad) begin
            fails++;
            $display("FAIL no_timeout: cp=%b credit=%0d busy=%b required 0 2 0", change_pulse, credit, busy);
         end
      end
`endif
   endtask

   task automatic test_random();
      logic [14:0] got, exp;
      do_reset();
      for (int n = 0; n < 800; n++) begin
         coin_valid = ($urandom_range(0, 9) < 3);
         coin_value = 2'($urandom_range(0, 3));
         sel_valid  = ($urandom_range(0, 3) == 0);
         item_sel   = ($urandom_range(0, 9) < 7) ? 4'(1 << $urandom_range(0, 3)) : 4'($urandom_range(0, 15));
         cancel     = ($urandom_range(0, 19) == 0);
         vend_ready = $urandom_range(0, 1) != 0;
         cycle();
         got = {vend_valid, vend_item, change_pulse, credit, busy, coin_reject, sel_err, sel_insuff};
         exp = {m_mode == 2, m_item, m_mode == 3, 4'(m_credit), m_mode >= 2, m_rej, m_serr, m_sins};
         tests++;
         if (got !== exp) begin
            fails++;
            $display("FAIL random cycle %0d: outputs=%h required %h", n, got, exp);
         end
      end
      quiet_inputs();
   endtask

   initial begin
      quiet_inputs();
      rst_n = 0;
      m_mode = 0; m_credit = 0; m_idle = 0; m_item = '0;
      m_rej = 0; m_serr = 0; m_sins = 0;
      @(negedge clk);
      test_reset();
      test_vend_change();
      test_insufficient();
      test_sel_err();
      test_overflow_refund();
      test_timeout();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
